// File: rtl/lane_request_arbiter.sv
// rtl/lane_request_arbiter.sv - debounced lane request latch with round-robin valid/ready offer
//
// Purpose: front end for the 4-approach traffic light controller. Raw lane
// buttons are synchronised, debounced on a slow sample tick, and each press
// is latched as a one-bit pending request. Pending lanes are offered one at
// a time in round-robin order; the controller consumes an offer by asserting
// req_ready while req_valid is high.
//
// Ports:
//   clkin      in   1  system clock, posedge
//   rst_n      in   1  asynchronous active-low reset
//   btn        in   4  raw asynchronous buttons, bit i = lane i, active-high
//   req_ready  in   1  controller accepts the current offer
//   req_valid  out  1  an offer is presented
//   req_lane   out  2  lane index of the offer, meaningful while req_valid=1
//   pend       out  4  latched pending requests (lamp drive)

module lane_request_arbiter #(
  parameter logic [15:0] DEB_DIV = 16'd50000,
  parameter int          DEB_CNT = 4
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       req_ready,
  output logic       req_valid,
  output logic [1:0] req_lane,
  output logic [3:0] pend
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  localparam logic [2:0]  DCNT_MAX = 3'(DEB_CNT - 1);
  localparam logic [15:0] DIV_MAX  = DEB_DIV - 16'd1;

  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [15:0] presc;
  logic        tick;
  logic [3:0]  stable;
  logic [3:0]  stable_d;
  logic [3:0]  rise;
  logic [2:0]  dcnt [4];
  logic [0:0]  state;
  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic [1:0]  idx;
  logic        found;
  logic        accept;
  logic [3:0]  clr;

  // Two-flop synchroniser per button.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Free-running sample prescaler; tick is high during the terminal count.
  assign tick = (presc == DIV_MAX);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A lane's debounced level only flips after DEB_CNT consecutive sample
  // ticks that disagree with it; any agreeing tick restarts the count.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        dcnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCNT_MAX) begin
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;

  // First pending lane at or after the round-robin pointer.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign accept = (state == S_OFFER) && req_ready;
  assign clr    = accept ? (4'b0001 << req_lane) : 4'b0000;

  // OR-ing rise after the clear lets a press that lands on the accepting
  // cycle survive, so the lane is simply re-offered later.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | rise;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_lane  <= 2'd0;
      ptr       <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pend) begin
            req_lane  <= sel;
            req_valid <= 1'b1;
            state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (req_ready) begin
            ptr       <= req_lane + 2'd1;
            req_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_request_arbiter.sv
// tb/tb_lane_request_arbiter.sv - self-checking bench for lane_request_arbiter

module tb_lane_request_arbiter;

  localparam int DIV = 4;
  localparam int CNT = 4;

  logic       clkin;
  logic       rst_n;
  logic [3:0] btn;
  logic       req_ready;
  logic       req_valid;
  logic [1:0] req_lane;
  logic [3:0] pend;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  int dut_acc[$];
  int dut_acc_t[$];

  lane_request_arbiter #(
    .DEB_DIV(16'(DIV)),
    .DEB_CNT(CNT)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .btn      (btn),
    .req_ready(req_ready),
    .req_valid(req_valid),
    .req_lane (req_lane),
    .pend     (pend)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model: button history, per-lane run of disagreeing samples,
  // a pending set and a round-robin offer chosen by scanning lanes.
  int       m_edges;
  bit [3:0] m_h1, m_h2;
  bit [3:0] m_level;
  bit [3:0] m_rise;
  bit [3:0] m_pend;
  int       m_run [4];
  bit       m_valid;
  int       m_lane;
  int       m_ptr;

  always @(posedge clkin or negedge rst_n) begin
    bit [3:0] seen;
    bit [3:0] rose;
    bit [3:0] clr;
    bit [3:0] old_pend;
    if (!rst_n) begin
      m_edges = 0;
      m_h1 = '0; m_h2 = '0; m_level = '0; m_rise = '0; m_pend = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_valid = 1'b0; m_lane = 0; m_ptr = 0;
    end else begin
      seen = m_h2;
      m_h2 = m_h1;
      m_h1 = btn;
      rose = '0;
      if ((m_edges % DIV) == DIV - 1) begin
        for (int i = 0; i < 4; i++) begin
          if (seen[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] >= CNT) begin
              m_level[i] = seen[i];
              m_run[i] = 0;
              rose[i] = seen[i];
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_edges++;
      old_pend = m_pend;
      clr = '0;
      if (!m_valid) begin
        if (old_pend != 0) begin
          for (int k = 3; k >= 0; k--) begin
            if (old_pend[(m_ptr + k) % 4]) m_lane = (m_ptr + k) % 4;
          end
          m_valid = 1'b1;
        end
      end else if (req_ready) begin
        clr[m_lane] = 1'b1;
        m_ptr = (m_lane + 1) % 4;
        m_valid = 1'b0;
      end
      m_pend = (old_pend & ~clr) | m_rise;
      m_rise = rose;
    end
  end

  always @(posedge clkin) begin
    cyc_no++;
    if (rst_n && req_valid && req_ready) begin
      dut_acc.push_back(int'(req_lane));
      dut_acc_t.push_back(cyc_no);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clkin);
      chk("model_valid", 32'(req_valid), 32'(m_valid));
      chk("model_pend", 32'(pend), 32'(m_pend));
      if (m_valid) chk("model_lane", 32'(req_lane), 32'(m_lane));
    end
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk({tag, "_count"}, 32'(dut_acc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_acc.size(); i++)
      chk({tag, "_lane"}, 32'(dut_acc[i]), 32'(exp[i]));
  endtask

  initial begin
    int n;
    int ex[$];
    btn = '0;
    req_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    chk("reset_valid", 32'(req_valid), 32'd0);
    chk("reset_lane", 32'(req_lane), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    rst_n = 1'b1;

    // Pulse spanning only three sample ticks must not register.
    cyc(2);
    btn[0] = 1'b1;
    cyc(3 * DIV);
    btn[0] = 1'b0;
    cyc(30);
    chk("short_pulse_pend", 32'(pend), 32'd0);

    // Bounce on lane 2, then a steady hold.
    for (int t = 0; t < 10; t++) begin
      btn[2] = ~btn[2];
      for (int c = 0; c < DIV; c++) begin
        cyc(1);
        chk("bounce_pend2", 32'(pend[2]), 32'd0);
      end
    end
    btn[2] = 1'b1;
    n = 0;
    while (!pend[2] && n < 40) begin cyc(1); n++; end
    chk("hold_pend2", 32'(pend[2]), 32'd1);
    checks++;
    assert (n >= 4 * DIV && n <= 5 * DIV - 1) else begin
      failures++;
      $error("FAIL hold_latency observed=%0d expected=%0d..%0d", n, 4 * DIV, 5 * DIV - 1);
    end
    cyc(3);
    chk("offer2_valid", 32'(req_valid), 32'd1);
    chk("offer2_lane", 32'(req_lane), 32'd2);

    // Asynchronous reset in the middle of an offer.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(req_valid), 32'd0);
    chk("async_rst_pend", 32'(pend), 32'd0);
    btn = '0;
    @(negedge clkin);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_lane", 32'(req_lane), 32'd0);
    chk("post_rst_pend", 32'(pend), 32'd0);

    // Round robin over all four lanes.
    btn = 4'hF;
    n = 0;
    while (pend != 4'hF && n < 40) begin cyc(1); n++; end
    chk("rr_all_pend", 32'(pend), 32'hF);
    dut_acc.delete(); dut_acc_t.delete();
    req_ready = 1'b1;
    cyc(8);
    req_ready = 1'b0;
    ex = '{0, 1, 2, 3};
    chk_log("rr", ex);
    for (int i = 1; i < dut_acc_t.size(); i++)
      chk("rr_gap", 32'(dut_acc_t[i] - dut_acc_t[i-1]), 32'd2);
    chk("rr_empty", 32'(pend), 32'd0);
    btn = '0;
    cyc(30);

    // Wrap from lane 3 back to lane 0.
    btn[3] = 1'b1;
    n = 0;
    while (!req_valid && n < 40) begin cyc(1); n++; end
    chk("wrap_first_lane", 32'(req_lane), 32'd3);
    btn[0] = 1'b1;
    n = 0;
    while (pend != 4'b1001 && n < 40) begin cyc(1); n++; end
    chk("wrap_pend", 32'(pend), 32'h9);
    dut_acc.delete(); dut_acc_t.delete();
    req_ready = 1'b1;
    cyc(4);
    req_ready = 1'b0;
    ex = '{3, 0};
    chk_log("wrap", ex);
    btn = '0;
    cyc(30);

    // Backpressure on lane 1 while lane 3 is pressed.
    btn[1] = 1'b1;
    n = 0;
    while (!req_valid && n < 40) begin cyc(1); n++; end
    btn[3] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      cyc(1);
      chk("bp_valid", 32'(req_valid), 32'd1);
      chk("bp_lane", 32'(req_lane), 32'd1);
    end
    chk("bp_pend", 32'(pend), 32'hA);
    dut_acc.delete(); dut_acc_t.delete();
    req_ready = 1'b1;
    cyc(4);
    req_ready = 1'b0;
    ex = '{1, 3};
    chk_log("bp", ex);
    btn = '0;
    cyc(30);

    // Re-press of lane 1 lands on the cycle lane 1 is accepted.
    btn[1] = 1'b1;
    n = 0;
    while (!req_valid && n < 40) begin cyc(1); n++; end
    chk("col_offer_lane", 32'(req_lane), 32'd1);
    btn[1] = 1'b0;
    btn[2] = 1'b1;
    n = 0;
    while ((m_level[1] || !pend[2]) && n < 40) begin cyc(1); n++; end
    chk("col_pend2", 32'(pend[2]), 32'd1);
    btn[1] = 1'b1;
    n = 0;
    while (!m_rise[1] && n < 40) begin cyc(1); n++; end
    chk("col_rise_seen", 32'(m_rise[1]), 32'd1);
    dut_acc.delete(); dut_acc_t.delete();
    req_ready = 1'b1;
    cyc(1);
    chk("col_pend1_kept", 32'(pend[1]), 32'd1);
    cyc(5);
    req_ready = 1'b0;
    ex = '{1, 2, 1};
    chk_log("col", ex);
    btn = '0;
    cyc(30);

    // Randomised buttons and backpressure against the model.
    for (int it = 0; it < 150; it++) begin
      btn = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 30);
      repeat (n) begin
        req_ready = ($urandom_range(0, 2) != 0);
        cyc(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
